dma_cmd_queue: RTL

- Command front-end sitting directly upstream of the DMA core.
- Buffers packed transfer commands (src, dst, mode) in a small FIFO.
- Issues them to the DMA core one at a time as a single-cycle start pulse with stable fields.
- Waits for the core's done level to rise before issuing the next command, so the core never sees a start while a transfer is in flight.

---
 rtl/dma_cmd_queue_if.sv | 48 ++++
 rtl/dma_cmd_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_queue_if.sv
// Command and DMA-core handshake bundle for dma_cmd_queue.
// master = upstream/core environment side, slave = the queue itself.
interface dma_cmd_queue_if #(
  parameter int LW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_data;
  logic          flush;
  logic          dma_start;
  logic [2:0]    dma_src;
  logic [2:0]    dma_dst;
  logic          dma_mode;
  logic          dma_done;
  logic          busy;
  logic [LW-1:0] queue_level;
  logic          timeout_err;

  modport master (
    output cmd_valid,
    output cmd_data,
    output flush,
    output dma_done,
    input  cmd_ready,
    input  dma_start,
    input  dma_src,
    input  dma_dst,
    input  dma_mode,
    input  busy,
    input  queue_level,
    input  timeout_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  flush,
    input  dma_done,
    output cmd_ready,
    output dma_start,
    output dma_src,
    output dma_dst,
    output dma_mode,
    output busy,
    output queue_level,
    output timeout_err
  );
endinterface

// File: rtl/dma_cmd_queue.sv
// Command FIFO in front of the DMA core: issues one start pulse per command and
// waits for a fresh done rising edge. Optional watchdog: define DMA_CMD_TIMEOUT_EN.
module dma_cmd_queue #(
  parameter int DEPTH          = 4,
  parameter int LW             = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             clk,
  input logic             rst,
  dma_cmd_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [6:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          start;
  logic          done_q;
  logic          done_rise;
  logic          timed_out;

  logic [2:0]    src_q;
  logic [2:0]    dst_q;
  logic          mode_q;

  // Bit 7 of a command carries no meaning for the core.
  logic          unused_cmd_bit;
  assign unused_cmd_bit = bus.cmd_data[7];

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign push      = bus.cmd_valid && !full && !bus.flush;
  assign done_rise = bus.dma_done && !done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.flush) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start   = 1'b1;
        state_d = ARM;
      end
      ARM: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (done_rise || timed_out) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Storage has no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.cmd_data[6:0];
    end
  end

  // Flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      mode_q <= 1'b0;
    end else if (pop) begin
      src_q  <= mem[rd_ptr][6:4];
      dst_q  <= mem[rd_ptr][3:1];
      mode_q <= mem[rd_ptr][0];
    end
  end

  // A done level left high by the previous transfer is captured in ARM so
  // only a genuine new rising edge can retire this command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (state_q == ARM || state_q == WAIT) begin
      done_q <= bus.dma_done;
    end
  end

`ifdef DMA_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer;
  logic          err_q;

  assign timed_out = (state_q == WAIT) && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state_q == ISSUE) begin
      timer <= '0;
    end else if (state_q == WAIT) begin
      timer <= timer + TW'(1);
    end
  end

  // A done edge arriving on the last allowed cycle still counts as success.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timed_out && !done_rise) begin
      err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = err_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timed_out          = 1'b0;
  assign bus.timeout_err    = 1'b0;
`endif

  assign bus.cmd_ready   = !full;
  assign bus.dma_start   = start;
  assign bus.dma_src     = src_q;
  assign bus.dma_dst     = dst_q;
  assign bus.dma_mode    = mode_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.queue_level = level;

endmodule
